char_rx_fifo: RTL and testbench
===============================

Name: char_rx_fifo

Overview:
- Consumer stage directly downstream of the terminal character source; accepts its `char`/`strobe` pulse stream.
- Buffers received characters in a FIFO and exposes them to the Cortex-M4 firmware through a small register-mapped slave port.
- Drives a level interrupt when data is pending, so firmware never misses keystrokes between polls.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width (derived, do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- char  in  8  character from the upstream source; valid only while strobe=1.
- strobe  in  1  one-cycle push pulse.
- sel  in  1  register access request, single cycle.
- wr  in  1  1=write, 0=read; sampled with sel.
- addr  in  2  word index: 0=DATA, 1=STATUS, 2=CTRL, 3=reserved.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- rvalid  out  1  one-cycle pulse, rdata valid.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync deassert, handled outside this block): FIFO empty, count=0, overflow=0, irq_en=0, rdata=0, rvalid=0, irq=0. Reset mid-transfer discards FIFO contents and any pending read.
- Push: strobe=1 and not full -> char written at wr_ptr, wr_ptr++ (wraps modulo DEPTH).
- Full push: strobe=1 and full -> character dropped; overflow sticky bit set.
- Read latency: sel=1 and wr=0 in cycle N -> rdata/rvalid in cycle N+1. rvalid=0 in every other cycle. rdata holds its last value when rvalid=0.
- DATA read:
  - rdata = {23'b0, valid, char}.
  - Non-empty: valid=1 and head popped in the same cycle as the request.
  - Empty: returns 0x0000_0000, no pop.
- STATUS read: bit0 = not empty, bit1 = full, bit2 = overflow, bits[15:8] = count (zero-extended), others 0.
- CTRL:
  - Read returns bit0 = irq_en.
  - Write: bit0 -> irq_en; bit1 = 1 clears overflow (write-one-to-clear, self-clearing, reads 0).
- Writes to DATA, STATUS and reserved addresses are ignored. Reserved reads return 0. Writes produce no rvalid.
- Simultaneous push and pop in the same cycle:
  - count unchanged; both pointers advance.
  - When full, the pop frees the slot, so the push is accepted (no overflow).
  - When empty, the push is not visible to the same-cycle pop (DATA returns empty).
- Overflow set and W1C in the same cycle: set wins.
- count arithmetic: CNT_W bits, saturates at DEPTH by construction. Full = (count==DEPTH), empty = (count==0).
- irq = irq_en & (not empty | overflow); registered, so it updates one cycle after the causing event.

Optional Feature:
- Macro: CHAR_RX_IRQ_THRESH_EN.
- Defined:
  - CTRL bits[15:8] = thresh, reset 1, read/write.
  - irq = irq_en & ((count >= thresh) | overflow).
  - thresh=0 is treated as 1.
  - CTRL read returns thresh in bits[15:8].
- Undefined: CTRL bits[15:8] are read-as-zero and write-ignored; irq uses not-empty as above.

Decomposition:
- Package char_rx_pkg holds:
  - register index localparams (REG_DATA=0, REG_STATUS=1, REG_CTRL=2);
  - STATUS/CTRL bit-position constants;
  - the DATA valid-bit position (8).
- Sub-module char_rx_sync_fifo:
  - generic DEPTH x 8 storage with pointers and count;
  - ports push/pop/din/dout/full/empty/count.
- Top level holds the register decode, overflow/irq logic and read pipeline.

Test Plan:
- Reset, then STATUS read -> rdata=0x0000_0000; rvalid exactly 1 cycle after sel.
- Strobes with 'A'(0x41), 'B'(0x42) -> STATUS=0x0000_0201; DATA reads return 0x141 then 0x142; a third DATA read returns 0x000.
- 17 strobes with DEPTH=16 -> STATUS=0x0000_1007 (count=16, full, overflow, avail). Write CTRL=0x2 -> overflow clears; first DATA read returns the first char, not the 17th.
- Full FIFO with strobe and DATA read in the same cycle -> no overflow; count stays 16; the new char is last out.
- CTRL=0x1 then one strobe -> irq rises 1 cycle later; after draining -> irq falls. With CHAR_RX_IRQ_THRESH_EN and thresh=4: irq stays low for 3 chars and rises on the 4th.
- Assert reset while FIFO holds 5 chars with a read in flight -> rvalid=0, count=0, irq=0 immediately.

Source files
------------

// File: rtl/char_rx_pkg.sv
// rtl/char_rx_pkg.sv - register map and bit positions for char_rx_fifo
//
// Shared constants for the character receive FIFO register slave.
// Optional feature macro: CHAR_RX_IRQ_THRESH_EN (adds CTRL threshold field).
package char_rx_pkg;

    // Register word indices
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // DATA register: {23'b0, valid, char}
    localparam int DATA_VALID_BIT = 8;

    // STATUS register fields
    localparam int STAT_NEMPTY_BIT = 0;
    localparam int STAT_FULL_BIT   = 1;
    localparam int STAT_OVF_BIT    = 2;
    localparam int STAT_COUNT_LSB  = 8;

    // CTRL register fields
    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_OVF_CLR_BIT = 1;

`ifdef CHAR_RX_IRQ_THRESH_EN
    localparam int CTRL_THRESH_LSB = 8;
    localparam int CTRL_THRESH_W   = 8;

    // A programmed threshold of zero behaves as one.
    function automatic logic [CTRL_THRESH_W-1:0] thresh_eff(input logic [CTRL_THRESH_W-1:0] t);
        return (t == '0) ? CTRL_THRESH_W'(1) : t;
    endfunction
`endif

endpackage

// File: rtl/char_rx_sync_fifo.sv
// rtl/char_rx_sync_fifo.sv - DEPTH x 8 synchronous FIFO with occupancy count
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, din         write request and data (dropped when full unless popping)
//   pop, dout         read request (ignored when empty); dout shows the head
//   full, empty       occupancy flags
//   count             number of stored entries, 0..DEPTH
module char_rx_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A pop on a full FIFO frees a slot for a same-cycle push; a push on an
    // empty FIFO is never visible to a same-cycle pop.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible through count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/char_rx_fifo.sv
// rtl/char_rx_fifo.sv - character receive FIFO with register slave and level irq
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   char, strobe      upstream character and one-cycle push pulse
//   sel, wr, addr     single-cycle register access (0=DATA 1=STATUS 2=CTRL 3=rsvd)
//   wdata             register write data
//   rdata, rvalid     registered read data, valid pulse one cycle after sel
//   irq               level interrupt
// Optional feature macro: CHAR_RX_IRQ_THRESH_EN (CTRL[15:8] irq threshold).
module char_rx_fifo
    import char_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char,
    input  logic        strobe,
    input  logic        sel,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        irq
);

    logic             do_read;
    logic             ctrl_wr;
    logic             pop_acc;
    logic             push_acc;
    logic             drop;
    logic [CNT_W-1:0] cnt_next;

    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic             overflow_q, overflow_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    assign do_read = sel & ~wr;
    assign ctrl_wr = sel & wr & (addr == REG_CTRL);

    // Acceptance mirrors the FIFO's own rules so overflow and the irq
    // next-state can be derived without waiting for the count to settle.
    assign pop_acc  = do_read & (addr == REG_DATA) & ~fifo_empty;
    assign push_acc = strobe & (~fifo_full | pop_acc);
    assign drop     = strobe & fifo_full & ~pop_acc;
    assign cnt_next = fifo_count + CNT_W'(push_acc) - CNT_W'(pop_acc);

    char_rx_sync_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (strobe),
        .pop   (pop_acc),
        .din   (char),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef CHAR_RX_IRQ_THRESH_EN
    logic [CTRL_THRESH_W-1:0] thresh_q, thresh_d;
    logic                     unused_wdata;
    assign unused_wdata = ^{wdata[31:16], wdata[7:2]};
`else
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:2];
`endif

    always_comb begin
        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;
        rdata_d    = rdata_q;
        rvalid_d   = do_read;
`ifdef CHAR_RX_IRQ_THRESH_EN
        thresh_d   = thresh_q;
`endif

        // Clear first so a same-cycle drop still sets the sticky bit.
        if (ctrl_wr) begin
            irq_en_d = wdata[CTRL_IRQ_EN_BIT];
            if (wdata[CTRL_OVF_CLR_BIT]) begin
                overflow_d = 1'b0;
            end
`ifdef CHAR_RX_IRQ_THRESH_EN
            thresh_d = wdata[CTRL_THRESH_LSB +: CTRL_THRESH_W];
`endif
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        if (do_read) begin
            rdata_d = '0;
            case (addr)
                REG_DATA: begin
                    if (!fifo_empty) begin
                        rdata_d[DATA_VALID_BIT] = 1'b1;
                        rdata_d[7:0]            = fifo_dout;
                    end
                end
                REG_STATUS: begin
                    rdata_d[STAT_NEMPTY_BIT] = ~fifo_empty;
                    rdata_d[STAT_FULL_BIT]   = fifo_full;
                    rdata_d[STAT_OVF_BIT]    = overflow_q;
                    // With DEPTH=256 the count field spills into bit 16.
                    rdata_d[STAT_COUNT_LSB +: CNT_W] = fifo_count;
                end
                REG_CTRL: begin
                    rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
`ifdef CHAR_RX_IRQ_THRESH_EN
                    rdata_d[CTRL_THRESH_LSB +: CTRL_THRESH_W] = thresh_q;
`endif
                end
                REG_RSVD: begin
                    rdata_d = '0;
                end
            endcase
        end

        // irq is computed from next-state values so it moves on the same
        // edge as the count/overflow change that causes it.
`ifdef CHAR_RX_IRQ_THRESH_EN
        irq_d = irq_en_d & ((9'(cnt_next) >= 9'(thresh_eff(thresh_d))) | overflow_d);
`else
        irq_d = irq_en_d & ((cnt_next != '0) | overflow_d);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
`ifdef CHAR_RX_IRQ_THRESH_EN
            thresh_q   <= CTRL_THRESH_W'(1);
`endif
        end else begin
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
`ifdef CHAR_RX_IRQ_THRESH_EN
            thresh_q   <= thresh_d;
`endif
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_char_rx_fifo.sv
// tb/tb_char_rx_fifo.sv - self-checking bench for char_rx_fifo
module tb_char_rx_fifo;

    localparam int DEPTH = 16;
`ifdef CHAR_RX_IRQ_THRESH_EN
    localparam logic [31:0] THR_RB = 32'h0000_0100;
`else
    localparam logic [31:0] THR_RB = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_in = '0;
    logic        strobe = 1'b0;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int checks = 0;
    int errors = 0;

    char_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .char   (char_in),
        .strobe (strobe),
        .sel    (sel),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: a queue of characters plus register state.
    byte unsigned mq[$];
    bit           m_ovf;
    bit           m_irq_en;
    int           m_thresh;
    logic [31:0]  m_rdata;
    bit           m_rvalid;
    bit           m_irq;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_irq_en = 0; m_thresh = 1;
        m_rdata = '0; m_rvalid = 0; m_irq = 0;
    endtask

    task automatic model_eval(input bit s, input logic [7:0] c, input bit se, input bit w,
                              input logic [1:0] a, input logic [31:0] wd);
        bit do_pop = 0;
        bit ovf_set = 0;
        int thr;
        m_rvalid = se && !w;
        if (se && !w) begin
            case (a)
                2'd0: begin
                    if (mq.size() > 0) begin
                        m_rdata = 32'h100 | 32'(mq[0]);
                        do_pop = 1;
                    end else m_rdata = 0;
                end
                2'd1: m_rdata = 32'(mq.size() > 0) | (32'(mq.size() == DEPTH) << 1)
                              | (32'(m_ovf) << 2) | (32'(mq.size()) << 8);
`ifdef CHAR_RX_IRQ_THRESH_EN
                2'd2: m_rdata = 32'(m_irq_en) | (32'(m_thresh) << 8);
`else
                2'd2: m_rdata = 32'(m_irq_en);
`endif
                default: m_rdata = 0;
            endcase
        end
        if (do_pop) void'(mq.pop_front());
        if (s) begin
            if (mq.size() < DEPTH) mq.push_back(c);
            else ovf_set = 1;
        end
        if (se && w && a == 2'd2) begin
            m_irq_en = wd[0];
            if (wd[1]) m_ovf = 0;
`ifdef CHAR_RX_IRQ_THRESH_EN
            m_thresh = int'(wd[15:8]);
`endif
        end
        if (ovf_set) m_ovf = 1;
`ifdef CHAR_RX_IRQ_THRESH_EN
        thr = (m_thresh == 0) ? 1 : m_thresh;
`else
        thr = 1;
`endif
        m_irq = m_irq_en && ((mq.size() >= thr) || m_ovf);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic [7:0] c, input bit se, input bit w,
                         input logic [1:0] a, input logic [31:0] wd);
        strobe = s; char_in = c; sel = se; wr = w; addr = a; wdata = wd;
    endtask

    // One cycle checked against the model.
    task automatic step(input string tag, input bit s, input logic [7:0] c, input bit se,
                        input bit w, input logic [1:0] a, input logic [31:0] wd);
        drive(s, c, se, w, a, wd);
        model_eval(s, c, se, w, a, wd);
        tick();
        check({tag, "_rdata"}, rdata, m_rdata);
        check({tag, "_rvalid"}, 32'(rvalid), 32'(m_rvalid));
        check({tag, "_irq"}, 32'(irq), 32'(m_irq));
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit          s;
        logic [7:0]  c;
        bit          se;
        bit          w;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [31:0] er;
        bit          ev;
        bit          ei;
    } vec_t;

    vec_t vt[$];

    function automatic void addv(bit s, logic [7:0] c, bit se, bit w, logic [1:0] a,
                                 logic [31:0] wd, logic [31:0] er, bit ev, bit ei);
        vec_t v;
        v.s = s; v.c = c; v.se = se; v.w = w; v.a = a; v.wd = wd;
        v.er = er; v.ev = ev; v.ei = ei;
        vt.push_back(v);
    endfunction

    initial begin
        // Directed table from reset: s, c, sel, wr, addr, wdata, exp rdata, rvalid, irq
        addv(0, 8'h00, 1, 0, 2'd1, 0,      32'h000, 1, 0); // STATUS after reset
        addv(0, 8'h00, 0, 0, 2'd0, 0,      32'h000, 0, 0);
        addv(1, 8'h41, 0, 0, 2'd0, 0,      32'h000, 0, 0); // 'A'
        addv(1, 8'h42, 0, 0, 2'd0, 0,      32'h000, 0, 0); // 'B'
        addv(0, 8'h00, 1, 0, 2'd1, 0,      32'h201, 1, 0);
        addv(0, 8'h00, 1, 0, 2'd0, 0,      32'h141, 1, 0);
        addv(0, 8'h00, 1, 0, 2'd0, 0,      32'h142, 1, 0);
        addv(0, 8'h00, 1, 0, 2'd0, 0,      32'h000, 1, 0); // empty DATA
        addv(0, 8'h00, 0, 0, 2'd0, 0,      32'h000, 0, 0);
        addv(0, 8'h00, 1, 1, 2'd2, 32'h1,  32'h000, 0, 0); // irq_en, still empty
        addv(1, 8'h43, 0, 0, 2'd0, 0,      32'h000, 0, 1); // irq 1 cycle later
        addv(0, 8'h00, 1, 0, 2'd2, 0,      32'h001 | THR_RB, 1, 1);
        addv(0, 8'h00, 1, 0, 2'd0, 0,      32'h143, 1, 0); // drain -> irq falls
        addv(0, 8'h00, 0, 0, 2'd0, 0,      32'h143, 0, 0); // rdata holds
        addv(0, 8'h00, 1, 0, 2'd3, 0,      32'h000, 1, 0); // reserved read
        addv(0, 8'h00, 1, 1, 2'd0, 32'hFF, 32'h000, 0, 0); // DATA write ignored
        addv(0, 8'h00, 1, 0, 2'd1, 0,      32'h000, 1, 0);
        addv(0, 8'h00, 1, 1, 2'd2, 32'h0,  32'h000, 0, 0);

        do_reset();
        check("reset_rdata", rdata, 32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].s, vt[i].c, vt[i].se, vt[i].w, vt[i].a, vt[i].wd);
            tick();
            check($sformatf("vec%0d_rdata", i), rdata, vt[i].er);
            check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vt[i].ev));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vt[i].ei));
        end

        // Overflow: 17 strobes into a 16-deep FIFO, then W1C.
        do_reset();
        for (int i = 0; i < 17; i++) step("ovf_fill", 1, 8'(8'h10 + i), 0, 0, 0, 0);
        step("ovf_stat", 0, 0, 1, 0, 2'd1, 0);
        check("ovf_status", rdata, 32'h0000_1007);
        step("ovf_clr", 0, 0, 1, 1, 2'd2, 32'h2);
        step("ovf_stat2", 0, 0, 1, 0, 2'd1, 0);
        check("ovf_status_cleared", rdata, 32'h0000_1003);
        step("ovf_first", 0, 0, 1, 0, 2'd0, 0);
        check("ovf_first_char", rdata, 32'h0000_0110);

        // Full FIFO: push and pop in the same cycle.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step("full_fill", 1, 8'(8'h20 + i), 0, 0, 0, 0);
        step("full_pp", 1, 8'h7E, 1, 0, 2'd0, 0);
        check("full_pp_head", rdata, 32'h0000_0120);
        step("full_stat", 0, 0, 1, 0, 2'd1, 0);
        check("full_pp_status", rdata, 32'h0000_1003);
        for (int i = 0; i < DEPTH; i++) step("full_drain", 0, 0, 1, 0, 2'd0, 0);
        check("full_last_out", rdata, 32'h0000_017E);

        // Overflow set and clear in the same cycle: set wins.
        for (int i = 0; i < DEPTH; i++) step("sw_fill", 1, 8'(i), 0, 0, 0, 0);
        step("sw_setclr", 1, 8'h55, 1, 1, 2'd2, 32'h2);
        step("sw_stat", 0, 0, 1, 0, 2'd1, 0);
        check("set_wins_status", rdata, 32'h0000_1007);

        // Empty FIFO: same-cycle push is not visible to the pop.
        do_reset();
        step("emp_pp", 1, 8'h5A, 1, 0, 2'd0, 0);
        check("empty_pp_data", rdata, 32'h0000_0000);
        step("emp_next", 0, 0, 1, 0, 2'd0, 0);
        check("empty_pp_next", rdata, 32'h0000_015A);

`ifdef CHAR_RX_IRQ_THRESH_EN
        // Threshold 4: irq rises only with the fourth character.
        do_reset();
        step("thr_cfg", 0, 0, 1, 1, 2'd2, 32'h0401);
        for (int i = 0; i < 3; i++) begin
            step("thr_fill", 1, 8'(8'h30 + i), 0, 0, 0, 0);
            check("thr_irq_low", 32'(irq), 32'h0);
        end
        step("thr_fourth", 1, 8'h33, 0, 0, 0, 0);
        check("thr_irq_high", 32'(irq), 32'h1);
`endif

        // Reset with 5 characters stored and a read in flight.
        do_reset();
        step("rst_en", 0, 0, 1, 1, 2'd2, 32'h1);
        for (int i = 0; i < 5; i++) step("rst_fill", 1, 8'(8'h60 + i), 0, 0, 0, 0);
        step("rst_rd", 0, 0, 1, 0, 2'd0, 0);
        drive(0, 0, 1, 0, 2'd0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_rvalid", 32'(rvalid), 32'h0);
        check("rst_async_irq", 32'(irq), 32'h0);
        check("rst_async_rdata", rdata, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        tick();
        reset = 1'b0;
        step("rst_stat", 0, 0, 1, 0, 2'd1, 0);
        check("rst_count_zero", rdata, 32'h0);

        // Randomized traffic against the model, in three strobe-density phases.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int sp;
            bit s, se, w;
            logic [1:0] a;
            logic [31:0] wd;
            sp = (i < 1000) ? 70 : (i < 2000) ? 35 : 10;
            s  = ($urandom_range(0, 99) < sp);
            se = ($urandom_range(0, 99) < 45);
            w  = se && ($urandom_range(0, 9) == 0);
            a  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            wd = $urandom;
            wd[15:8] = 8'($urandom_range(0, 6));
            step("rand", s, 8'($urandom), se, w, a, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
